inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 26 ++
 rtl/inst_queue_mem.sv | 36 +++
 rtl/inst_queue.sv | 97 +++++++++
 tb/tb_inst_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
//   Shared constants and types for the instruction queue.
//   DEFAULT_WIDTH : default instruction / PC width in bits
//   DEFAULT_DEPTH : default number of queue entries (power of two, >= 2)
//   DEFAULT_PTR_W : pointer width for the default depth
//   ptr_width()   : pointer width for an arbitrary legal depth
//   q_op_e        : per-cycle queue operation, encoded as {push, pop}
package inst_queue_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/inst_queue_mem.sv
// inst_queue_mem
//   DEPTH x 2*WIDTH register array holding {pc, inst} pairs.
//   One synchronous write port, one asynchronous (combinational) read port.
//   Contents are never reset; only written entries are ever read as valid.
//   Ports:
//     clk       : clock
//     i_wr_en   : write enable
//     i_wr_addr : write address
//     i_wr_data : {pc, inst} to store
//     i_rd_addr : read address
//     o_rd_data : {pc, inst} stored at i_rd_addr
module inst_queue_mem
  import inst_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        i_wr_en,
  input  logic [ptr_width(DEPTH)-1:0] i_wr_addr,
  input  logic [2*WIDTH-1:0]          i_wr_data,
  input  logic [ptr_width(DEPTH)-1:0] i_rd_addr,
  output logic [2*WIDTH-1:0]          o_rd_data
);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_queue.sv
// inst_queue
//   Fetch-side instruction FIFO feeding the IF/ID register. One-cycle
//   latency, no empty bypass, no full pass-through, flush empties the queue.
//   Ports:
//     clk       : clock, all state on rising edge
//     rst       : synchronous active-low reset
//     flush     : discard all queued entries (overrides push/pop)
//     in_valid  : upstream offers {in_pc, in_inst}
//     in_ready  : queue accepts an entry this cycle
//     in_pc     : PC of offered instruction
//     in_inst   : offered instruction word
//     out_valid : head entry available
//     out_ready : downstream accepts head
//     out_pc    : head PC (0 when empty)
//     out_inst  : head instruction (0 when empty)
//     count     : occupancy 0..DEPTH
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_pc,
  input  logic [WIDTH-1:0]          in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_pc,
  output logic [WIDTH-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_push;
  logic               w_pop;
  q_op_e              w_op;
  logic [2*WIDTH-1:0] w_rd_data;

  // in_ready is held low while reset is asserted so nothing is accepted
  // in a cycle whose state is being discarded anyway.
  assign in_ready  = rst && (r_count != CNT_FULL) && !flush;
  assign out_valid = (r_count != '0);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_op   = q_op_e'({w_push, w_pop});

  inst_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({in_pc, in_inst}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Storage is never cleared, so stale slots must be masked when empty.
  assign out_pc   = out_valid ? w_rd_data[2*WIDTH-1:WIDTH] : '0;
  assign out_inst = out_valid ? w_rd_data[WIDTH-1:0]       : '0;
  assign count    = r_count;

  // Pointers are exactly PW bits with DEPTH a power of two, so the +1
  // wraps DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case (w_op)
        Q_PUSH:  r_count <= r_count + CNT_ONE;
        Q_POP:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue
//   Directed scenarios followed by random traffic, every cycle checked
//   against a queue-based reference model of the instruction FIFO.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_pc;
  logic [W-1:0]   in_inst;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_pc;
  logic [W-1:0]   out_inst;
  logic [$clog2(D):0] count;

  always #5 clk = ~clk;

  inst_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  // Reference model: entries as {pc, inst}, head at index 0.
  logic [2*W-1:0] model_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] inst_of(input logic [W-1:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_inst;
    logic [2*W-1:0] head;
    n = model_q.size();
    e_pc = '0;
    e_inst = '0;
    if (n > 0) begin
      head = model_q[0];
      e_pc = head[2*W-1:W];
      e_inst = head[W-1:0];
    end
    chk("count",     W'(count),     W'(n));
    chk("in_ready",  W'(in_ready),  W'(rst && (n != D) && !flush));
    chk("out_valid", W'(out_valid), W'(n != 0));
    chk("out_pc",    out_pc,        e_pc);
    chk("out_inst",  out_inst,      e_inst);
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, then
  // advance the model by the queue's rules.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] pc, input logic ordy);
    int n;
    logic do_push;
    logic do_pop;
    logic [2*W-1:0] popped;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy;
    #1;
    check_outputs();
    n = model_q.size();
    do_push = r && !f && iv && (n < D);
    do_pop  = r && !f && ordy && (n > 0);
    @(posedge clk);
    if (!r || f) begin
      model_q.delete();
      $display("t=%0t %s", $time, !r ? "reset" : "flush");
    end else begin
      if (do_pop) begin
        popped = model_q.pop_front();
        $display("t=%0t pop  pc=%08h", $time, popped[2*W-1:W]);
      end
      if (do_push) begin
        model_q.push_back({pc, inst_of(pc)});
        $display("t=%0t push pc=%08h", $time, pc);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_q.delete();

    // Reset held: in_ready low, empty.
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

    // Fill to full with out_ready=0, then a fifth offer is refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, W'(i * 4), 1'b0);
    chk("full_count", W'(count), 32'd4);
    cycle(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    chk("full_stays", W'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drained_count", W'(count), 32'd0);
    chk("drained_valid", W'(out_valid), 32'd0);

    // Steady push+pop at count 2, pointers wrap several times.
    cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h104, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, W'(32'h108 + i * 4), 1'b1);
      chk("steady_count", W'(count), 32'd2);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush at count 3 with an in-flight offer.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, W'(32'h200 + i * 4), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hDEAD0, 1'b0);
    chk("flush_count", W'(count), 32'd0);
    chk("flush_valid", W'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Mid-operation reset at count 2, then push into empty with out_ready=1.
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h304, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_count", W'(count), 32'd0);
    chk("rst_pc",    out_pc,    32'd0);
    chk("rst_inst",  out_inst,  32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
    chk("nobypass_valid", W'(out_valid), 32'd1);
    chk("nobypass_pc",    out_pc,        32'h400);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(31) != 0), ($urandom_range(15) == 0),
            1'($urandom), W'($urandom) & 32'hFFFF_FFFC, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
